// File: rtl/ddr_line_responder_pkg.sv
// Shared constants and FSM state encoding for the DDR line responder.
package ddr_line_responder_pkg;

  localparam int LINE_W   = 128;
  localparam int ADDR_W   = 27;
  localparam int OFFSET_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;
  localparam logic [1:0] ST_FIN     = 2'd3;

endpackage

// File: rtl/ddr_line_responder_line_ram.sv
// Single-port line store with synchronous read-first output; no reset so it maps to block RAM.
module line_ram
  import ddr_line_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [2**AW];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ddr_line_responder.sv
// Fixed-latency line read/write responder: one-deep pending slot per request type, writes win in IDLE.
// Handshake: *_en is a one-cycle pulse with no backpressure; *_fin is a one-cycle completion pulse.
module ddr_line_responder
  import ddr_line_responder_pkg::*;
#(
  parameter int LINE_ADDR_W = 10,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] cache2DDR_rd_addr,
  input  logic              cache2DDR_rd_en,
  output logic              DDR2cache_rd_fin,
  output logic [LINE_W-1:0] DDR2cache_rd_data,
  input  logic [ADDR_W-1:0] cache2DDR_wr_addr,
  input  logic [LINE_W-1:0] cache2DDR_wr_data,
  input  logic              cache2DDR_wr_en,
  output logic              DDR2cache_wr_fin,
  output logic              err_overflow,
  output logic [1:0]        dbg_state_o
);

  logic [1:0]             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [LINE_ADDR_W-1:0] rd_line_q, rd_line_d, wr_line_q, wr_line_d;
  logic [LINE_W-1:0]      wr_data_q, wr_data_d;
  logic                   rd_fin_q, rd_fin_d, wr_fin_q, wr_fin_d;
  logic [LINE_W-1:0]      hold_q, hold_d;
  logic                   err_q, err_d;

  logic [LINE_ADDR_W-1:0] rd_line_in, wr_line_in, rd_line_sel, wr_line_sel, ram_addr;
  logic [LINE_W-1:0]      wr_data_sel, ram_rdata;
  logic                   start_wr, start_rd, ram_en;
  logic                   unused_addr_bits;

  assign rd_line_in = cache2DDR_rd_addr[OFFSET_W +: LINE_ADDR_W];
  assign wr_line_in = cache2DDR_wr_addr[OFFSET_W +: LINE_ADDR_W];
  assign unused_addr_bits = ^{cache2DDR_rd_addr, cache2DDR_wr_addr};

  // A queued request takes precedence over a fresh pulse of the same type.
  assign rd_line_sel = rd_pend_q ? rd_line_q : rd_line_in;
  assign wr_line_sel = wr_pend_q ? wr_line_q : wr_line_in;
  assign wr_data_sel = wr_pend_q ? wr_data_q : cache2DDR_wr_data;

  assign start_wr = (state_q == ST_IDLE) && (wr_pend_q || cache2DDR_wr_en);
  assign start_rd = (state_q == ST_IDLE) && !start_wr && (rd_pend_q || cache2DDR_rd_en);

  assign ram_en   = rstn && (start_wr || start_rd);
  assign ram_addr = start_wr ? wr_line_sel : rd_line_sel;

  line_ram #(.AW(LINE_ADDR_W)) u_line_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (start_wr),
    .addr_i  (ram_addr),
    .wdata_i (wr_data_sel),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rd_pend_d = rd_pend_q;
    rd_line_d = rd_line_q;
    wr_pend_d = wr_pend_q;
    wr_line_d = wr_line_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    if (start_wr) wr_pend_d = 1'b0;
    if (start_rd) rd_pend_d = 1'b0;
    // A fresh pulse not consumed directly needs a free (or freeing) slot, else it is lost.
    if (cache2DDR_wr_en && !(start_wr && !wr_pend_q)) begin
      if (!wr_pend_q || start_wr) begin
        wr_pend_d = 1'b1;
        wr_line_d = wr_line_in;
        wr_data_d = cache2DDR_wr_data;
      end else begin
        err_d = 1'b1;
      end
    end
    if (cache2DDR_rd_en && !(start_rd && !rd_pend_q)) begin
      if (!rd_pend_q || start_rd) begin
        rd_pend_d = 1'b1;
        rd_line_d = rd_line_in;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_fin_d = 1'b0;
    wr_fin_d = 1'b0;
    hold_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_wr) begin
          state_d = ST_WR_WAIT;
          cnt_d   = 4'(LATENCY - 2);
        end else if (start_rd) begin
          state_d = ST_RD_WAIT;
          cnt_d   = 4'(LATENCY - 2);
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_FIN;
          rd_fin_d = (state_q == ST_RD_WAIT);
          wr_fin_d = (state_q == ST_WR_WAIT);
          if (state_q == ST_RD_WAIT) hold_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_line_q <= '0;
      wr_pend_q <= 1'b0;
      wr_line_q <= '0;
      wr_data_q <= '0;
      rd_fin_q  <= 1'b0;
      wr_fin_q  <= 1'b0;
      hold_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_line_q <= rd_line_d;
      wr_pend_q <= wr_pend_d;
      wr_line_q <= wr_line_d;
      wr_data_q <= wr_data_d;
      rd_fin_q  <= rd_fin_d;
      wr_fin_q  <= wr_fin_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
    end
  end

  assign DDR2cache_rd_fin  = rd_fin_q;
  assign DDR2cache_wr_fin  = wr_fin_q;
  assign DDR2cache_rd_data = hold_q;
  assign err_overflow      = err_q;
  assign dbg_state_o       = state_q;

endmodule

// File: doc/ddr_line_responder.md
DDR_LINE_RESPONDER -- requirements
Module: ddr_line_responder

Interface
REQ-001 SHALL have parameter LINE_ADDR_W, default 10; meaning: log2 of stored line count (1024 lines x 128 bit).
REQ-002 SHALL have parameter LATENCY, default 4; meaning: cycles from request sample to fin pulse, legal range 2..15.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  synchronous active-low reset.
REQ-005 SHALL have port cache2DDR_rd_addr  input  27  byte address of line to read; bits [3:0] ignored.
REQ-006 SHALL have port cache2DDR_rd_en  input  1  one-cycle read request pulse.
REQ-007 SHALL have port DDR2cache_rd_fin  output  1  one-cycle pulse, read data valid.
REQ-008 SHALL have port DDR2cache_rd_data  output  128  line data; word k in bits [32k+31:32k].
REQ-009 SHALL have port cache2DDR_wr_addr  input  27  byte address of line to write; bits [3:0] ignored.
REQ-010 SHALL have port cache2DDR_wr_data  input  128  full line to write.
REQ-011 SHALL have port cache2DDR_wr_en  input  1  one-cycle write request pulse.
REQ-012 SHALL have port DDR2cache_wr_fin  output  1  one-cycle pulse, write committed.
REQ-013 SHALL have port err_overflow  output  1  sticky flag, a request was dropped.

Function
REQ-014 SHALL map line index = addr[4+LINE_ADDR_W-1:4]; bits above are ignored (aliasing).
REQ-015 SHALL capture each request pulse into a one-deep pending slot per type (rd: addr; wr: addr+data) on the cycle it is sampled high.
REQ-016 SHALL use FSM states IDLE, RD_WAIT, WR_WAIT, FIN.
REQ-017 In IDLE, a pending write SHALL be started before a pending read; a request sampled in the same cycle is started that cycle (zero queue delay).
REQ-018 Started write: line RAM written on start cycle, latency counter loaded, FSM -> WR_WAIT.
REQ-019 Started read: line RAM read issued on start cycle, counter loaded, FSM -> RD_WAIT; RAM output registered into a holding register.
REQ-020 When counter expires, FSM -> FIN; fin of the active type SHALL be high exactly one cycle, the cycle LATENCY after the request was sampled (idle case).
REQ-021 DDR2cache_rd_data SHALL equal the line during rd_fin and 128'd0 on every other cycle.
REQ-022 FIN -> IDLE next cycle; back-to-back operations therefore spaced LATENCY+1 cycles apart.
REQ-023 Simultaneous rd_en and wr_en to the same line SHALL return the newly written data on the subsequent rd_fin.
REQ-024 A request arriving while its own slot is still pending (not yet started) SHALL be dropped and err_overflow set; a request to a busy block with an empty slot SHALL be queued.
REQ-025 rd_fin and wr_fin SHALL never be high in the same cycle.
REQ-026 Line RAM contents SHALL persist across reset; simulation initial contents zero.

Reset
REQ-027 On rstn low: FSM -> IDLE, pending slots cleared, counter 0, DDR2cache_rd_fin=0, DDR2cache_wr_fin=0, DDR2cache_rd_data=0, err_overflow=0.
REQ-028 Reset mid-operation SHALL abort it with no fin pulse; a write whose start cycle already occurred remains in RAM.
REQ-029 Requests sampled while rstn low SHALL be ignored.

Structure
REQ-030 Shared package SHALL hold LINE_W=128, ADDR_W=27, OFFSET_W=4, and the FSM state encoding.
REQ-031 Storage SHALL be one sub-module line_ram: single-port, synchronous read, 128 x 2^LINE_ADDR_W, BRAM-inferable, no reset.

Verification
REQ-032 Write 0x…0004_0003_0002_0001 to addr 0x0000120 at T -> wr_fin at T+4 only; read addr 0x0000128 at T+6 -> rd_fin at T+10, rd_data identical, rd_data 0 at T+9 and T+11.
REQ-033 rd_en and wr_en same cycle, addr 0x40, data all-ones -> wr_fin at T+4, rd_fin at T+9 with all-ones.
REQ-034 Read issued at T, second read at T+1, third at T+2 -> fins at T+4, T+9; third dropped, err_overflow=1 from T+3 until reset.
REQ-035 Write at T, rstn low at T+2 for one cycle -> no wr_fin; later read of same line returns written data, err_overflow=0.
REQ-036 Addresses 0x0000010 and 0x0004010 (LINE_ADDR_W=10) alias: write A to first, read second -> A.
REQ-037 Random rd/wr stream against reference memory model, 10k requests, one outstanding -> zero mismatches, fin never coincident.
